// File: rtl/bus_master_arbiter_pkg.sv
// bus_master_arbiter_pkg: shared constants, state encoding and round-robin helper for the bus arbiter
package bus_master_arbiter_pkg;
  localparam int BUS_MASTER_NUMBER = 3;
  localparam int BUS_TIMEOUT_CYCLES = 255;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_e;
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return i == 2'd2 ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/bus_master_arbiter_rr_picker.sv
// bus_rr_picker: combinational round-robin pick, searching from last+1 modulo 3
module bus_rr_picker
  import bus_master_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_NUMBER-1:0] req,
  input  logic [1:0]                   last,
  output logic [BUS_MASTER_NUMBER-1:0] pick,
  output logic                         valid
);
  logic [1:0] p0, p1, p2;
  assign p0 = rr_next(last);
  assign p1 = rr_next(p0);
  assign p2 = rr_next(p1);
  assign pick = req[p0] ? 3'b001 << p0 : req[p1] ? 3'b001 << p1 : req[p2] ? 3'b001 << p2 : 3'b000;
  assign valid = |req;
endmodule

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: round-robin arbiter sharing one bus master port among CPU data (m0), CPU fetch (m1) and DMA (m2)
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_CYCLES,
  parameter int CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  input  logic        m2_stb_i,
  input  logic        m2_we_i,
  input  logic [31:0] m2_adr_i,
  input  logic [31:0] m2_dat_i,
  output logic [31:0] m2_dat_o,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  input  logic        bus_adr_err_i,
  output logic [2:0]  grant_o,
  output logic        timeout_o
);
  arb_state_e state, state_nxt;
  logic [BUS_MASTER_NUMBER-1:0] stb, pick;
  logic [1:0] last, gi;
  logic [CNT_W-1:0] cnt;
  logic valid, busy, g_stb, abort, adr_err, ack, tmo, done, err;
  assign stb = {m2_stb_i, m1_stb_i, m0_stb_i};
  bus_rr_picker u_picker (.req(stb), .last(last), .pick(pick), .valid(valid));
  assign busy = state == ARB_BUSY;
  assign gi = grant_o[2] ? 2'd2 : grant_o[1] ? 2'd1 : 2'd0;
  assign g_stb = |(stb & grant_o);
  assign abort = busy & ~g_stb;
  assign adr_err = busy & g_stb & bus_adr_err_i;
  assign ack = busy & g_stb & ~bus_adr_err_i & bus_ack_i;
  assign tmo = busy & g_stb & ~bus_adr_err_i & ~bus_ack_i & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done = adr_err | ack | tmo;
  assign err = adr_err | tmo;
  always_ff @(posedge clk_i) state <= rst_i ? ARB_IDLE : state_nxt;
  always_comb state_nxt = busy ? ((abort | done) ? ARB_IDLE : ARB_BUSY) : (valid ? ARB_BUSY : ARB_IDLE);
  always_comb begin
    bus_stb_o = busy;
    bus_we_o  = grant_o[2] ? m2_we_i  : grant_o[1] ? m1_we_i  : m0_we_i;
    bus_adr_o = grant_o[2] ? m2_adr_i : grant_o[1] ? m1_adr_i : m0_adr_i;
    bus_dat_o = grant_o[2] ? m2_dat_i : grant_o[1] ? m1_dat_i : m0_dat_i;
    m0_ack_o = done & grant_o[0];
    m1_ack_o = done & grant_o[1];
    m2_ack_o = done & grant_o[2];
    m0_err_o = err & grant_o[0];
    m1_err_o = err & grant_o[1];
    m2_err_o = err & grant_o[2];
    m0_dat_o = (busy & grant_o[0] & ~adr_err) ? bus_dat_i : '0;
    m1_dat_o = (busy & grant_o[1] & ~adr_err) ? bus_dat_i : '0;
    m2_dat_o = (busy & grant_o[2] & ~adr_err) ? bus_dat_i : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_o <= '0;
      last <= 2'd2;
      cnt <= '0;
      timeout_o <= 1'b0;
    end else if (!busy) begin
      grant_o <= pick;
      cnt <= '0;
    end else if (abort | done) begin
      grant_o <= '0;
      last <= gi;
      if (tmo) timeout_o <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: table vectors, corner sequences and randomized traffic checked against a behavioural model
module tb_bus_master_arbiter;
  localparam int T = 4;
  logic clk = 0, rst;
  logic [2:0] stb, we, ack, err, grant, s_grant, s_ack, s_err, e_ack_q;
  logic [31:0] adr [3], wdat [3], rdat [3], s_rdat [3];
  logic bus_stb, bus_we, bus_ack, bus_aerr, timeout, s_stb, s_timeout;
  logic [31:0] bus_adr, bus_dat_o, bus_dat_i;
  int checks = 0, errors = 0;
  int owner, wcnt, last;
  bit tflag;
  always #5 clk = ~clk;
  bus_master_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(rdat[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
    .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(rdat[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
    .m2_stb_i(stb[2]), .m2_we_i(we[2]), .m2_adr_i(adr[2]), .m2_dat_i(wdat[2]), .m2_dat_o(rdat[2]), .m2_ack_o(ack[2]), .m2_err_o(err[2]),
    .bus_stb_o(bus_stb), .bus_we_o(bus_we), .bus_adr_o(bus_adr), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_ack_i(bus_ack), .bus_adr_err_i(bus_aerr), .grant_o(grant), .timeout_o(timeout)
  );
  typedef struct packed {
    logic rst;
    logic [2:0] stb;
    logic ack, aerr, e_stb;
    logic [2:0] e_grant, e_ack, e_err;
  } vec_t;
  vec_t tbl [18];
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cycle();
    logic [2:0] e_ack, e_err;
    logic [31:0] e_dat [3];
    bit fin, tmo;
    @(negedge clk);
    e_ack = 0; e_err = 0; fin = 0; tmo = 0;
    e_dat = '{default: 0};
    if (owner >= 0) begin
      e_dat[owner] = (stb[owner] && bus_aerr) ? 32'h0 : bus_dat_i;
      if (stb[owner]) begin
        if (bus_aerr) begin fin = 1; e_err[owner] = 1; end
        else if (bus_ack) fin = 1;
        else if (wcnt == T - 1) begin fin = 1; tmo = 1; e_err[owner] = 1; end
        e_ack[owner] = fin;
      end
    end
    s_stb = bus_stb; s_grant = grant; s_ack = ack; s_err = err; s_timeout = timeout; s_rdat = rdat;
    e_ack_q = e_ack;
    chk("bus_stb", bus_stb, owner >= 0);
    chk("grant", grant, owner >= 0 ? 3'(1 << owner) : 3'b000);
    chk("ack", ack, e_ack);
    chk("err", err, e_err);
    chk("rdat", {rdat[2], rdat[1], rdat[0]}, {e_dat[2], e_dat[1], e_dat[0]});
    chk("timeout", timeout, tflag);
    if (owner >= 0) chk("bus_req", {bus_we, bus_adr, bus_dat_o}, {we[owner], adr[owner], wdat[owner]});
    @(posedge clk);
    if (rst) begin
      owner = -1; last = 2; tflag = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= 3; k++)
        if (owner < 0 && stb[(last + k) % 3]) begin owner = (last + k) % 3; wcnt = 0; end
    end else if (!stb[owner] || fin) begin
      last = owner; owner = -1;
      if (tmo) tflag = 1;
    end else wcnt++;
    #1;
  endtask
  task automatic do_reset();
    rst = 1; stb = 0; bus_ack = 0; bus_aerr = 0;
    cycle();
    rst = 0;
  endtask
  initial begin
    int n_stb, n_ack, n_oth, ack_at;
    logic [31:0] got;
    rst = 1; stb = 0; we = 0; bus_ack = 0; bus_aerr = 0; bus_dat_i = 0; e_ack_q = 0;
    for (int i = 0; i < 3; i++) begin adr[i] = 32'h1000 * (i + 1); wdat[i] = 32'hA000_0000 + i; end
    repeat (2) @(posedge clk);
    #1;
    owner = -1; last = 2; tflag = 0; wcnt = 0;
    do_reset();
    tbl[0]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 3'b001, 3'b000};
    tbl[2]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[3]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b010, 3'b010, 3'b000};
    tbl[4]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[5]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b100, 3'b100, 3'b000};
    tbl[6]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[7]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 3'b001, 3'b000};
    tbl[8]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[9]  = '{1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[10] = '{1'b0, 3'b100, 1'b0, 1'b1, 1'b1, 3'b100, 3'b100, 3'b100};
    tbl[11] = '{1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[12] = '{1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 3'b001, 3'b001, 3'b000};
    tbl[13] = '{1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[14] = '{1'b0, 3'b101, 1'b1, 1'b0, 1'b1, 3'b100, 3'b100, 3'b000};
    tbl[15] = '{1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[16] = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 3'b001, 3'b000, 3'b000};
    tbl[17] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
    bus_dat_i = 32'h1234_5678;
    we = 3'b101;
    for (int i = 0; i < 18; i++) begin
      logic [31:0] td [3];
      rst = tbl[i].rst; stb = tbl[i].stb; bus_ack = tbl[i].ack; bus_aerr = tbl[i].aerr;
      for (int n = 0; n < 3; n++) td[n] = (tbl[i].e_grant[n] && !(tbl[i].aerr && tbl[i].stb[n])) ? bus_dat_i : 32'h0;
      cycle();
      chk($sformatf("tbl%0d_stb", i), s_stb, tbl[i].e_stb);
      chk($sformatf("tbl%0d_grant", i), s_grant, tbl[i].e_grant);
      chk($sformatf("tbl%0d_ack", i), s_ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d_err", i), s_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_rdat", i), {s_rdat[2], s_rdat[1], s_rdat[0]}, {td[2], td[1], td[0]});
    end
    rst = 0;
    do_reset();
    adr[0] = 32'h0000_0100; we[0] = 0; stb = 3'b001; bus_dat_i = 32'hDEAD_BEEF;
    n_stb = 0; n_ack = 0; n_oth = 0; got = 0;
    repeat (8) begin
      bus_ack = owner >= 0 && wcnt == 2;
      cycle();
      n_stb += int'(s_stb);
      if (s_ack[0]) begin n_ack++; got = s_rdat[0]; end
      if (s_ack[2:1] != 0 || s_rdat[1] != 0 || s_rdat[2] != 0) n_oth++;
      if (e_ack_q[0]) stb[0] = 0;
    end
    chk("read_stb_cycles", n_stb, 3);
    chk("read_ack_count", n_ack, 1);
    chk("read_data", got, 32'hDEAD_BEEF);
    chk("read_others_quiet", n_oth, 0);
    do_reset();
    stb = 3'b010; ack_at = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_ack[1] && s_err[1] && ack_at < 0) ack_at = i;
      if (e_ack_q[1]) stb[1] = 0;
    end
    chk("timeout_cycle", ack_at, 4);
    chk("timeout_sticky", s_timeout, 1);
    do_reset();
    cycle();
    chk("timeout_cleared", s_timeout, 0);
    do_reset();
    stb = 3'b011;
    cycle();
    cycle();
    stb = 3'b010;
    cycle();
    chk("abort_no_ack", {s_stb, s_ack}, {1'b1, 3'b000});
    cycle();
    chk("abort_idle", s_stb, 0);
    cycle();
    chk("abort_next_grant", s_grant, 3'b010);
    bus_ack = 1;
    cycle();
    stb = 0; bus_ack = 0;
    cycle();
    do_reset();
    stb = 3'b010;
    cycle();
    cycle();
    chk("mid_rst_granted", s_grant, 3'b010);
    rst = 1;
    cycle();
    rst = 0; stb = 3'b111;
    cycle();
    chk("mid_rst_dropped", {s_grant, s_stb, s_ack}, {3'b000, 1'b0, 3'b000});
    cycle();
    chk("mid_rst_first_m0", s_grant, 3'b001);
    stb = 0;
    cycle();
    cycle();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (stb[i] && e_ack_q[i]) stb[i] = $urandom_range(0, 1) == 0;
        else if (stb[i] && $urandom_range(0, 39) == 0) stb[i] = 0;
        else if (!stb[i] && $urandom_range(0, 2) == 0) stb[i] = 1;
        if (stb[i] && (e_ack_q[i] || !(owner == i))) begin
          if (e_ack_q[i] || $urandom_range(0, 3) == 0) begin
            adr[i] = $urandom; wdat[i] = $urandom; we[i] = 1'($urandom_range(0, 1));
          end
        end
      end
      bus_ack = $urandom_range(0, 2) == 0;
      bus_aerr = $urandom_range(0, 9) == 0;
      bus_dat_i = $urandom;
      rst = $urandom_range(0, 199) == 0;
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
